// File: rtl/ex_mem.sv
// EX/MEM pipeline register: PASS/BUBBLE/HOLD per stall[4:3], with a hilo/cnt loop-back for multi-cycle madd/msub.
// Optional load/store side-band fields are enabled by defining EX_MEM_LS_EN.
module ex_mem #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       stall,
  input  logic [4:0]       ex_wd,
  input  logic             ex_wreg,
  input  logic [31:0]      ex_wdata,
  input  logic [31:0]      ex_hi,
  input  logic [31:0]      ex_lo,
  input  logic             ex_whilo,
  input  logic [63:0]      hilo_i,
  input  logic [CNT_W-1:0] cnt_i,
`ifdef EX_MEM_LS_EN
  input  logic [7:0]       ex_aluop,
  input  logic [31:0]      ex_mem_addr,
  input  logic [31:0]      ex_reg2,
  output logic [7:0]       mem_aluop,
  output logic [31:0]      mem_mem_addr,
  output logic [31:0]      mem_reg2,
`endif
  output logic [4:0]       mem_wd,
  output logic             mem_wreg,
  output logic [31:0]      mem_wdata,
  output logic [31:0]      mem_hi,
  output logic [31:0]      mem_lo,
  output logic             mem_whilo,
  output logic [63:0]      hilo_o,
  output logic [CNT_W-1:0] cnt_o
);

  logic             ex_stall;
  logic             mem_stall;
  logic             unused_stall_bits;

  logic [4:0]       wd_q, wd_d;
  logic             wreg_q, wreg_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic             whilo_q, whilo_d;
  logic [63:0]      hilo_q, hilo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef EX_MEM_LS_EN
  logic [7:0]       aluop_q, aluop_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [31:0]      reg2_q, reg2_d;
`endif

  assign ex_stall          = stall[3];
  assign mem_stall         = stall[4];
  assign unused_stall_bits = ^{stall[5], stall[2:0]};

  // MEM stalled while EX runs cannot happen upstream; it falls into the PASS branch.
  always_comb begin
    wd_d    = wd_q;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    whilo_d = whilo_q;
    hilo_d  = hilo_q;
    cnt_d   = cnt_q;
`ifdef EX_MEM_LS_EN
    aluop_d    = aluop_q;
    mem_addr_d = mem_addr_q;
    reg2_d     = reg2_q;
`endif
    if (!ex_stall) begin
      wd_d    = ex_wd;
      wreg_d  = ex_wreg;
      wdata_d = ex_wdata;
      hi_d    = ex_hi;
      lo_d    = ex_lo;
      whilo_d = ex_whilo;
      hilo_d  = '0;
      cnt_d   = '0;
`ifdef EX_MEM_LS_EN
      aluop_d    = ex_aluop;
      mem_addr_d = ex_mem_addr;
      reg2_d     = ex_reg2;
`endif
    end else if (!mem_stall) begin
      // Bubble into MEM while the partial product circulates back to EX.
      wd_d    = '0;
      wreg_d  = 1'b0;
      wdata_d = '0;
      hi_d    = '0;
      lo_d    = '0;
      whilo_d = 1'b0;
      hilo_d  = hilo_i;
      cnt_d   = cnt_i;
`ifdef EX_MEM_LS_EN
      aluop_d    = '0;
      mem_addr_d = '0;
      reg2_d     = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_q    <= '0;
      wreg_q  <= 1'b0;
      wdata_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      whilo_q <= 1'b0;
      hilo_q  <= '0;
      cnt_q   <= '0;
`ifdef EX_MEM_LS_EN
      aluop_q    <= '0;
      mem_addr_q <= '0;
      reg2_q     <= '0;
`endif
    end else begin
      wd_q    <= wd_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      whilo_q <= whilo_d;
      hilo_q  <= hilo_d;
      cnt_q   <= cnt_d;
`ifdef EX_MEM_LS_EN
      aluop_q    <= aluop_d;
      mem_addr_q <= mem_addr_d;
      reg2_q     <= reg2_d;
`endif
    end
  end

  assign mem_wd    = wd_q;
  assign mem_wreg  = wreg_q;
  assign mem_wdata = wdata_q;
  assign mem_hi    = hi_q;
  assign mem_lo    = lo_q;
  assign mem_whilo = whilo_q;
  assign hilo_o    = hilo_q;
  assign cnt_o     = cnt_q;
`ifdef EX_MEM_LS_EN
  assign mem_aluop    = aluop_q;
  assign mem_mem_addr = mem_addr_q;
  assign mem_reg2     = reg2_q;
`endif

endmodule

// File: tb/tb_ex_mem.sv
// Self-checking bench for ex_mem: directed scenarios plus randomized stall traffic against a behavioural model.
module tb_ex_mem;
  localparam int CNT_W = 2;
`ifdef EX_MEM_LS_EN
  localparam int VW = 169 + 72;
`else
  localparam int VW = 169;
`endif

  logic             clk;
  logic             rst;
  logic [5:0]       stall;
  logic [4:0]       ex_wd;
  logic             ex_wreg;
  logic [31:0]      ex_wdata, ex_hi, ex_lo;
  logic             ex_whilo;
  logic [63:0]      hilo_i;
  logic [CNT_W-1:0] cnt_i;
  logic [4:0]       mem_wd;
  logic             mem_wreg;
  logic [31:0]      mem_wdata, mem_hi, mem_lo;
  logic             mem_whilo;
  logic [63:0]      hilo_o;
  logic [CNT_W-1:0] cnt_o;
`ifdef EX_MEM_LS_EN
  logic [7:0]       ex_aluop, mem_aluop;
  logic [31:0]      ex_mem_addr, mem_mem_addr, ex_reg2, mem_reg2;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: what MEM and the EX loop-back should be holding right now.
  logic [4:0]       m_wd;
  logic             m_wreg, m_whilo;
  logic [31:0]      m_wdata, m_hi, m_lo;
  logic [63:0]      m_hilo;
  logic [CNT_W-1:0] m_cnt;
`ifdef EX_MEM_LS_EN
  logic [7:0]       m_aluop;
  logic [31:0]      m_addr, m_reg2;
`endif

  ex_mem #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
    .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_whilo(ex_whilo),
    .hilo_i(hilo_i), .cnt_i(cnt_i),
`ifdef EX_MEM_LS_EN
    .ex_aluop(ex_aluop), .ex_mem_addr(ex_mem_addr), .ex_reg2(ex_reg2),
    .mem_aluop(mem_aluop), .mem_mem_addr(mem_mem_addr), .mem_reg2(mem_reg2),
`endif
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_whilo(mem_whilo),
    .hilo_o(hilo_o), .cnt_o(cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [VW-1:0] dut_vec();
    return {mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo, hilo_o, cnt_o
`ifdef EX_MEM_LS_EN
            , mem_aluop, mem_mem_addr, mem_reg2
`endif
           };
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    return {m_wd, m_wreg, m_wdata, m_hi, m_lo, m_whilo, m_hilo, m_cnt
`ifdef EX_MEM_LS_EN
            , m_aluop, m_addr, m_reg2
`endif
           };
  endfunction

  task automatic model_clear();
    m_wd = '0; m_wreg = 0; m_wdata = '0; m_hi = '0; m_lo = '0; m_whilo = 0;
    m_hilo = '0; m_cnt = '0;
`ifdef EX_MEM_LS_EN
    m_aluop = '0; m_addr = '0; m_reg2 = '0;
`endif
  endtask

  // One clock edge as seen by the pipeline: EX either advances, injects a NOP, or everything freezes.
  task automatic model_edge();
    bit ex_moves, mem_frozen;
    ex_moves   = (stall[3] == 1'b0);
    mem_frozen = stall[3] && stall[4];
    if (ex_moves) begin
      m_wd = ex_wd; m_wreg = ex_wreg; m_wdata = ex_wdata; m_hi = ex_hi; m_lo = ex_lo;
      m_whilo = ex_whilo; m_hilo = '0; m_cnt = '0;
`ifdef EX_MEM_LS_EN
      m_aluop = ex_aluop; m_addr = ex_mem_addr; m_reg2 = ex_reg2;
`endif
    end else if (!mem_frozen) begin
      model_clear();
      m_hilo = hilo_i;
      m_cnt  = cnt_i;
    end
  endtask

  task automatic tick();
    if (rst) model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_inputs();
    ex_wd = 5'($urandom); ex_wreg = 1'($urandom); ex_wdata = $urandom;
    ex_hi = $urandom; ex_lo = $urandom; ex_whilo = 1'($urandom);
    hilo_i = {$urandom, $urandom}; cnt_i = CNT_W'($urandom);
`ifdef EX_MEM_LS_EN
    ex_aluop = 8'($urandom); ex_mem_addr = $urandom; ex_reg2 = $urandom;
`endif
  endtask

  task automatic test_reset();
    rst = 1'b0; stall = '0; rand_inputs();
    model_clear();
    #2;
    n_checks++;
    if (dut_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL reset_state got=%h exp=%h", dut_vec(), exp_vec());
    end
    @(posedge clk); #1;
    n_checks++;
    if (dut_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL reset_held_over_edge got=%h exp=%h", dut_vec(), exp_vec());
    end
    #3 rst = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_pass();
    rand_inputs();
    stall = 6'b000000; ex_wd = 5'h1F; ex_wreg = 1'b1; ex_wdata = 32'hDEADBEEF;
    tick();
    n_checks++;
    if ({mem_wd, mem_wreg, mem_wdata} !== {5'h1F, 1'b1, 32'hDEADBEEF}) begin
      n_fail++; $display("FAIL pass_fields got=%h/%b/%h exp=1f/1/deadbeef", mem_wd, mem_wreg, mem_wdata);
    end
    n_checks++;
    if (hilo_o !== 64'd0 || cnt_o !== '0) begin
      n_fail++; $display("FAIL pass_loopback_clear hilo=%h cnt=%0d exp=0/0", hilo_o, cnt_o);
    end
    n_checks++;
    if (dut_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL pass_all got=%h exp=%h", dut_vec(), exp_vec());
    end
    $display("test_pass wd=%h wdata=%h", mem_wd, mem_wdata);
  endtask

  task automatic test_bubble_chain();
    rand_inputs();
    ex_wreg = 1'b1; ex_whilo = 1'b1;
    stall = 6'b001111; hilo_i = 64'h0000_0001_0000_0002; cnt_i = 1;
    tick();
    n_checks++;
    if (cnt_o !== CNT_W'(1) || hilo_o !== 64'h0000_0001_0000_0002 || mem_wreg !== 1'b0 || mem_whilo !== 1'b0) begin
      n_fail++; $display("FAIL bubble1 cnt=%0d hilo=%h wreg=%b whilo=%b exp=1/0000000100000002/0/0", cnt_o, hilo_o, mem_wreg, mem_whilo);
    end
    hilo_i = 64'h0000_0003_0000_0004; cnt_i = 2;
    tick();
    n_checks++;
    if (cnt_o !== CNT_W'(2) || hilo_o !== 64'h0000_0003_0000_0004 || mem_wreg !== 1'b0 || mem_whilo !== 1'b0) begin
      n_fail++; $display("FAIL bubble2 cnt=%0d hilo=%h wreg=%b whilo=%b exp=2/0000000300000004/0/0", cnt_o, hilo_o, mem_wreg, mem_whilo);
    end
    n_checks++;
    if (dut_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL bubble_all got=%h exp=%h", dut_vec(), exp_vec());
    end
    $display("test_bubble_chain cnt=%0d hilo=%h", cnt_o, hilo_o);
  endtask

  task automatic test_hold();
    logic [63:0] hilo_before;
    logic [CNT_W-1:0] cnt_before;
    rand_inputs();
    stall = 6'b000000; ex_wdata = 32'h12345678;
    tick();
    hilo_before = m_hilo; cnt_before = m_cnt;
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      stall = 6'b011111; ex_wdata = 32'hFFFFFFFF;
      tick();
      n_checks++;
      if (mem_wdata !== 32'h12345678 || hilo_o !== hilo_before || cnt_o !== cnt_before) begin
        n_fail++; $display("FAIL hold_cycle%0d wdata=%h hilo=%h cnt=%0d exp=12345678/%h/%0d", i, mem_wdata, hilo_o, cnt_o, hilo_before, cnt_before);
      end
    end
    // Hold with a live loop-back value: bubble first, then freeze.
    stall = 6'b001000; hilo_i = 64'hCAFE_0000_BEEF_0001; cnt_i = 3;
    tick();
    for (int i = 0; i < 2; i++) begin
      rand_inputs();
      stall = 6'b011000;
      tick();
      n_checks++;
      if (hilo_o !== 64'hCAFE_0000_BEEF_0001 || cnt_o !== CNT_W'(3)) begin
        n_fail++; $display("FAIL hold_loopback%0d hilo=%h cnt=%0d exp=cafe0000beef0001/3", i, hilo_o, cnt_o);
      end
    end
    $display("test_hold wdata=%h", mem_wdata);
  endtask

  task automatic test_illegal();
    rand_inputs();
    stall = 6'b010000; ex_whilo = 1'b1; ex_hi = 32'hA5A5A5A5;
    tick();
    n_checks++;
    if (mem_whilo !== 1'b1 || mem_hi !== 32'hA5A5A5A5 || hilo_o !== 64'd0 || cnt_o !== '0) begin
      n_fail++; $display("FAIL illegal_as_pass whilo=%b hi=%h hilo=%h cnt=%0d exp=1/a5a5a5a5/0/0", mem_whilo, mem_hi, hilo_o, cnt_o);
    end
    $display("test_illegal hi=%h", mem_hi);
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    for (int i = 0; i < 300; i++) begin
      rand_inputs();
      stall = 6'($urandom);
      tick();
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; errs++;
        $display("FAIL random_%0d stall=%b got=%h exp=%h", i, stall, dut_vec(), exp_vec());
      end
    end
    $display("test_random 300 cycles, %0d mismatching", errs);
  endtask

  task automatic test_async_reset();
    rand_inputs();
    stall = 6'b001000; hilo_i = 64'h1111_2222_3333_4444; cnt_i = 2;
    tick();
    #2 rst = 1'b0;
    model_clear();
    #1;
    n_checks++;
    if (dut_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL async_reset_midcycle got=%h exp=0", dut_vec());
    end
    #2 rst = 1'b1;
    rand_inputs();
    stall = 6'b001000; hilo_i = 64'h5555_6666_7777_8888; cnt_i = 1;
    tick();
    n_checks++;
    if (dut_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL reset_release_edge got=%h exp=%h", dut_vec(), exp_vec());
    end
    $display("test_async_reset cnt=%0d", cnt_o);
  endtask

`ifdef EX_MEM_LS_EN
  task automatic test_ls();
    rand_inputs();
    stall = 6'b000000; ex_mem_addr = 32'h8000_0010; ex_aluop = 8'h23;
    tick();
    n_checks++;
    if (mem_mem_addr !== 32'h8000_0010 || mem_aluop !== 8'h23) begin
      n_fail++; $display("FAIL ls_pass addr=%h aluop=%h exp=80000010/23", mem_mem_addr, mem_aluop);
    end
    stall = 6'b001000;
    tick();
    n_checks++;
    if (mem_mem_addr !== 32'd0 || mem_aluop !== 8'd0 || mem_reg2 !== 32'd0) begin
      n_fail++; $display("FAIL ls_bubble addr=%h aluop=%h reg2=%h exp=0/0/0", mem_mem_addr, mem_aluop, mem_reg2);
    end
    $display("test_ls addr=%h", mem_mem_addr);
  endtask
`endif

  initial begin
    test_reset();
    test_pass();
    test_bubble_chain();
    test_hold();
    test_illegal();
    test_random();
    test_async_reset();
`ifdef EX_MEM_LS_EN
    test_ls();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
